// File: rtl/stack_pkg.sv
// stack_pkg: shared types and helpers for the eForth data-stack controller.
//   stack_op_e : 3-bit stack opcode (6 and 7 behave as NOP)
//   state_e    : controller state (IDLE accepts ops, FILL refills nos from memory)
//   min_depth  : number of live cells an opcode needs before it may execute
package stack_pkg;
  localparam int DSZ_DEF   = 32;
  localparam int DEPTH_DEF = 64;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_DROP = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_OVER = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } stack_op_e;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;
  function automatic logic [1:0] min_depth(input stack_op_e op);
    return (op == OP_SWAP || op == OP_OVER) ? 2'd2 :
           (op == OP_DROP || op == OP_DUP)  ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/stack_ctl.sv
// stack_ctl: data-stack controller caching TOS/NOS in registers, spilling/filling
// the third cell to an external push/pop stack memory.
//   clk, rst_n            : clock, asynchronous active-low reset
//   op_valid/op_ready/op  : stack op handshake, din is the PUSH literal
//   err_clr               : clears sticky err_uf/err_of (a new error in the same cycle wins)
//   tos, nos, depth       : cached cells and live cell count (0..DEPTH+2)
//   s_push, s_vi          : registered spill strobe and data to stack memory
//   s_pop, s_vo           : registered fill strobe and popped data, captured in FILL
module stack_ctl
  import stack_pkg::*;
#(
  parameter int DSZ   = DSZ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SSZ   = $clog2(DEPTH + 3)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] din,
  input  logic           err_clr,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] nos,
  output logic [SSZ-1:0] depth,
  output logic           err_uf,
  output logic           err_of,
  output logic           s_push,
  output logic           s_pop,
  output logic [DSZ-1:0] s_vi,
  input  logic [DSZ-1:0] s_vo
);
  state_e          r_state, w_state_nxt;
  logic [DSZ-1:0]  r_tos, r_nos, r_s_vi, w_tos_nxt, w_nos_nxt;
  logic [SSZ-1:0]  r_depth, w_depth_nxt;
  logic            r_err_uf, r_err_of, r_s_push, r_s_pop;
  stack_op_e       w_op;
  logic            w_acc, w_push_type, w_uf, w_of, w_fire, w_spill, w_pop;

  assign w_op        = stack_op_e'(op);
  assign op_ready    = (r_state == IDLE);
  assign w_acc       = op_valid & op_ready;
  assign w_push_type = (w_op == OP_PUSH) | (w_op == OP_DUP) | (w_op == OP_OVER);
  assign w_uf        = r_depth < SSZ'(min_depth(w_op));
  assign w_of        = w_push_type & (r_depth == SSZ'(DEPTH + 2));
  assign w_fire      = w_acc & ~w_uf & ~w_of;
  // Only the third cell down lives in memory, so traffic starts once both caches are full.
  assign w_spill     = w_fire & w_push_type & (r_depth >= SSZ'(2));
  assign w_pop       = w_fire & (w_op == OP_DROP) & (r_depth > SSZ'(2));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;

  always_comb
    w_state_nxt = (r_state == FILL) ? IDLE : (w_pop ? FILL : IDLE);

  always_comb begin
    w_tos_nxt   = r_tos;
    w_nos_nxt   = (r_state == FILL) ? s_vo : r_nos;
    w_depth_nxt = r_depth;
    if (w_fire)
      case (w_op)
        OP_PUSH: begin
          w_tos_nxt   = din;
          w_nos_nxt   = r_tos;
          w_depth_nxt = r_depth + SSZ'(1);
        end
        OP_DUP: begin
          w_nos_nxt   = r_tos;
          w_depth_nxt = r_depth + SSZ'(1);
        end
        OP_OVER: begin
          w_tos_nxt   = r_nos;
          w_nos_nxt   = r_tos;
          w_depth_nxt = r_depth + SSZ'(1);
        end
        OP_SWAP: begin
          w_tos_nxt = r_nos;
          w_nos_nxt = r_tos;
        end
        OP_DROP: begin
          // Deep stacks keep nos until FILL overwrites it with the popped cell.
          w_tos_nxt   = r_nos;
          w_nos_nxt   = (r_depth > SSZ'(2)) ? r_nos : '0;
          w_depth_nxt = r_depth - SSZ'(1);
        end
        default: ;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tos    <= '0;
      r_nos    <= '0;
      r_depth  <= '0;
      r_err_uf <= 1'b0;
      r_err_of <= 1'b0;
      r_s_push <= 1'b0;
      r_s_pop  <= 1'b0;
      r_s_vi   <= '0;
    end else begin
      r_tos    <= w_tos_nxt;
      r_nos    <= w_nos_nxt;
      r_depth  <= w_depth_nxt;
      r_err_uf <= (w_acc & w_uf) | (r_err_uf & ~err_clr);
      r_err_of <= (w_acc & w_of) | (r_err_of & ~err_clr);
      r_s_push <= w_spill;
      r_s_pop  <= w_pop;
      if (w_spill) r_s_vi <= r_nos;
    end

  assign tos    = r_tos;
  assign nos    = r_nos;
  assign depth  = r_depth;
  assign err_uf = r_err_uf;
  assign err_of = r_err_of;
  assign s_push = r_s_push;
  assign s_pop  = r_s_pop;
  assign s_vi   = r_s_vi;
endmodule

// File: tb/tb_stack_ctl.sv
// tb_stack_ctl: directed table-driven bench for stack_ctl with a behavioural stack memory.
module tb_stack_ctl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] din = '0;
  logic        err_clr = 1'b0;
  logic [31:0] tos, nos, s_vi, s_vo;
  logic [6:0]  depth;
  logic        err_uf, err_of, s_push, s_pop;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int n_pop   = 0;
  int n_both  = 0;
  logic [31:0] last_vi = '0;

  stack_ctl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .din(din), .err_clr(err_clr), .tos(tos), .nos(nos), .depth(depth),
    .err_uf(err_uf), .err_of(err_of), .s_push(s_push), .s_pop(s_pop),
    .s_vi(s_vi), .s_vo(s_vo)
  );

  always #5 clk = ~clk;

  // Memory model: top cell visible on s_vo, push/pop applied at the clock edge.
  logic [31:0] mem [64];
  int sp;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) sp <= 0;
    else if (s_push && sp < 64) begin
      mem[sp] <= s_vi;
      sp <= sp + 1;
    end else if (s_pop && sp > 0) sp <= sp - 1;
  assign s_vo = (sp > 0) ? mem[sp-1] : 32'h0;

  always @(negedge clk) begin
    if (s_push) begin
      n_push++;
      last_vi = s_vi;
    end
    if (s_pop) n_pop++;
    if (s_push && s_pop) n_both++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] o, input logic [31:0] d, input logic c, output int lat);
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    din = d;
    err_clr = c;
    @(negedge clk);
    op_valid = 1'b0;
    op = 3'd0;
    err_clr = 1'b0;
    lat = 0;
    while (!op_ready && lat < 8) begin
      lat++;
      @(negedge clk);
    end
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] din;
    logic        clr;
    logic [31:0] tos;
    logic [31:0] nos;
    int          depth;
    logic        uf;
    logic        of_;
    int          npush;
    logic [31:0] vi;
    int          npop;
    int          lat;
  } vec_t;

  vec_t v[22];

  initial begin
    int lat, p0, q0, acc;
    //         op    din     clr  tos     nos     d  uf of  np vi     npop lat
    v[0]  = '{3'd1, 32'h11, 1'b0, 32'h11, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0};
    v[1]  = '{3'd1, 32'h22, 1'b0, 32'h22, 32'h11, 2, 0, 0, 0, 32'h0,  0, 0};
    v[2]  = '{3'd1, 32'h33, 1'b0, 32'h33, 32'h22, 3, 0, 0, 1, 32'h11, 0, 0};
    v[3]  = '{3'd4, 32'h0,  1'b0, 32'h22, 32'h33, 3, 0, 0, 0, 32'h0,  0, 0};
    v[4]  = '{3'd5, 32'h0,  1'b0, 32'h33, 32'h22, 4, 0, 0, 1, 32'h33, 0, 0};
    v[5]  = '{3'd2, 32'h0,  1'b0, 32'h22, 32'h33, 3, 0, 0, 0, 32'h0,  1, 1};
    v[6]  = '{3'd2, 32'h0,  1'b0, 32'h33, 32'h11, 2, 0, 0, 0, 32'h0,  1, 1};
    v[7]  = '{3'd3, 32'h0,  1'b0, 32'h33, 32'h33, 3, 0, 0, 1, 32'h11, 0, 0};
    v[8]  = '{3'd2, 32'h0,  1'b0, 32'h33, 32'h11, 2, 0, 0, 0, 32'h0,  1, 1};
    v[9]  = '{3'd2, 32'h0,  1'b0, 32'h11, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0};
    v[10] = '{3'd4, 32'h0,  1'b0, 32'h11, 32'h0,  1, 1, 0, 0, 32'h0,  0, 0};
    v[11] = '{3'd0, 32'h0,  1'b1, 32'h11, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0};
    v[12] = '{3'd2, 32'h0,  1'b0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  0, 0};
    v[13] = '{3'd2, 32'h0,  1'b0, 32'h0,  32'h0,  0, 1, 0, 0, 32'h0,  0, 0};
    v[14] = '{3'd3, 32'h0,  1'b0, 32'h0,  32'h0,  0, 1, 0, 0, 32'h0,  0, 0};
    v[15] = '{3'd0, 32'h0,  1'b1, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  0, 0};
    v[16] = '{3'd5, 32'h0,  1'b0, 32'h0,  32'h0,  0, 1, 0, 0, 32'h0,  0, 0};
    v[17] = '{3'd1, 32'h44, 1'b1, 32'h44, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0};
    v[18] = '{3'd7, 32'h55, 1'b0, 32'h44, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0};
    v[19] = '{3'd5, 32'h0,  1'b1, 32'h44, 32'h0,  1, 1, 0, 0, 32'h0,  0, 0};
    v[20] = '{3'd0, 32'h0,  1'b1, 32'h44, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0};
    v[21] = '{3'd6, 32'h77, 1'b0, 32'h44, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0};

    #12;
    chk("rst tos", tos, 32'h0);
    chk("rst depth", 32'(depth), 32'd0);
    chk("rst op_ready", 32'(op_ready), 32'd1);
    chk("rst strobes", {30'd0, s_push, s_pop}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      p0 = n_push;
      q0 = n_pop;
      step(v[i].op, v[i].din, v[i].clr, lat);
      chk($sformatf("v%0d tos", i), tos, v[i].tos);
      chk($sformatf("v%0d nos", i), nos, v[i].nos);
      chk($sformatf("v%0d depth", i), 32'(depth), 32'(v[i].depth));
      chk($sformatf("v%0d err_uf", i), 32'(err_uf), 32'(v[i].uf));
      chk($sformatf("v%0d err_of", i), 32'(err_of), 32'(v[i].of_));
      chk($sformatf("v%0d s_push count", i), 32'(n_push - p0), 32'(v[i].npush));
      if (v[i].npush != 0) chk($sformatf("v%0d s_vi", i), last_vi, v[i].vi);
      chk($sformatf("v%0d s_pop count", i), 32'(n_pop - q0), 32'(v[i].npop));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(v[i].lat));
    end

    // Fill to capacity, overflow, then drain in LIFO order.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 66; i++) step(3'd1, 32'(i), 1'b0, lat);
    chk("full depth", 32'(depth), 32'd66);
    chk("full tos", tos, 32'd65);
    chk("full nos", nos, 32'd64);
    chk("full err_of pre", 32'(err_of), 32'd0);
    step(3'd1, 32'h99, 1'b0, lat);
    chk("ovf err_of", 32'(err_of), 32'd1);
    chk("ovf depth", 32'(depth), 32'd66);
    chk("ovf tos", tos, 32'd65);
    for (int i = 65; i >= 0; i--) begin
      chk($sformatf("drain tos %0d", i), tos, 32'(i));
      step(3'd2, 32'h0, 1'b0, lat);
    end
    chk("drain depth", 32'(depth), 32'd0);
    chk("drain tos", tos, 32'd0);
    chk("drain nos", nos, 32'd0);
    chk("drain err_uf", 32'(err_uf), 32'd0);

    // Back-to-back DROPs are accepted every other cycle.
    for (int i = 1; i <= 5; i++) step(3'd1, 32'(i), 1'b0, lat);
    @(negedge clk);
    op_valid = 1'b1;
    op = 3'd2;
    acc = 0;
    repeat (4) begin
      if (op_ready) acc++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    op = 3'd0;
    #1;
    chk("b2b accepts", 32'(acc), 32'd2);
    chk("b2b depth", 32'(depth), 32'd3);
    chk("b2b tos", tos, 32'd3);
    chk("b2b nos", nos, 32'd2);

    // Reset while a FILL is in flight.
    @(negedge clk);
    op_valid = 1'b1;
    op = 3'd2;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op = 3'd0;
    chk("fill op_ready", 32'(op_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst tos", tos, 32'h0);
    chk("arst nos", nos, 32'h0);
    chk("arst depth", 32'(depth), 32'd0);
    chk("arst s_vi", s_vi, 32'h0);
    chk("arst strobes", {28'd0, s_push, s_pop, err_uf, err_of}, 32'd0);
    chk("arst op_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'd1, 32'hA5, 1'b0, lat);
    chk("post tos", tos, 32'hA5);
    chk("post nos", nos, 32'h0);
    chk("post depth", 32'(depth), 32'd1);
    chk("push/pop overlap", 32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
